// File: rtl/sd_data_pkg.sv
// Shared types and constants for the SD host DATA control path.
package sd_data_pkg;

    localparam int BLK_W_DEF = 4;
    localparam int TO_W_DEF  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIFO,
        S_STROBE,
        S_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CRC     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/sd_data_if.sv
// Register/FIFO/DATA-phy signal bundle seen by sd_data_control.
// master: the control unit; slave: register file, FIFO and physical layer.
interface sd_data_if import sd_data_pkg::*; #(
    parameter int BLK_W = BLK_W_DEF,
    parameter int TO_W  = TO_W_DEF
) ();
    logic             start_DMA;
    logic             writeRead_REG;
    logic             multiple_REG;
    logic [BLK_W-1:0] blocks_REG;
    logic [TO_W-1:0]  timeout_REG;
    logic             fifo_ok_FIFO;
    logic             complete_Phy;
    logic             crc_err_Phy;

    logic             strobe_OUT_DATA_Phy;
    logic             ack_OUT_DATA_Phy;
    logic             writeRead_DATA_Phy;
    logic             multiple_DATA_Phy;
    logic [BLK_W-1:0] blocks_DATA_Phy;
    logic [TO_W-1:0]  timeout_Reg_DATA_Phy;
    logic             busy;
    logic [BLK_W-1:0] blocks_done;
    logic [1:0]       err_code;
    logic             transfer_complete_IRQ;
    logic             error_IRQ;

    modport master (
        input  start_DMA, writeRead_REG, multiple_REG, blocks_REG, timeout_REG,
               fifo_ok_FIFO, complete_Phy, crc_err_Phy,
        output strobe_OUT_DATA_Phy, ack_OUT_DATA_Phy, writeRead_DATA_Phy,
               multiple_DATA_Phy, blocks_DATA_Phy, timeout_Reg_DATA_Phy, busy,
               blocks_done, err_code, transfer_complete_IRQ, error_IRQ
    );

    modport slave (
        output start_DMA, writeRead_REG, multiple_REG, blocks_REG, timeout_REG,
               fifo_ok_FIFO, complete_Phy, crc_err_Phy,
        input  strobe_OUT_DATA_Phy, ack_OUT_DATA_Phy, writeRead_DATA_Phy,
               multiple_DATA_Phy, blocks_DATA_Phy, timeout_Reg_DATA_Phy, busy,
               blocks_done, err_code, transfer_complete_IRQ, error_IRQ
    );
endinterface

// File: rtl/sd_data_watchdog.sv
// Strobe watchdog: counts cycles while enabled, flags the cycle whose
// incremented count reaches a non-zero limit.
module sd_data_watchdog import sd_data_pkg::*; #(
    parameter int TO_W = TO_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_clr,
    input  logic [TO_W-1:0] i_limit,
    output logic            o_expired
);
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + TO_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Comparing the next count makes the strobe last exactly i_limit cycles.
    assign o_expired = i_en && (i_limit != '0) && (w_cnt_nxt == i_limit);
endmodule

// File: rtl/sd_data_control.sv
// SD host DATA control FSM: latches a transfer request and runs per-block
// strobe/ack handshakes with the DATA phy. Optional: SD_DATA_CTRL_WATCHDOG_EN.
module sd_data_control import sd_data_pkg::*; #(
    parameter int BLK_W = BLK_W_DEF,
    parameter int TO_W  = TO_W_DEF
) (
    input  logic      SD_CLK,
    input  logic      RESET,
    sd_data_if.master bus
);
    state_t           r_state, w_state_nxt;
    logic             r_wr, r_mul, r_pend_err;
    logic [BLK_W-1:0] r_blocks, r_target, r_done_cnt, w_target;
    logic [TO_W-1:0]  r_timeout;
    logic [1:0]       r_err, w_err_val;
    logic             w_latch, w_blk_inc, w_err_set, w_expired;

    // Single-block requests and a zero count both mean one block.
    assign w_target = (!bus.multiple_REG || bus.blocks_REG == '0) ? BLK_W'(1)
                                                                  : bus.blocks_REG;

`ifdef SD_DATA_CTRL_WATCHDOG_EN
    sd_data_watchdog #(.TO_W(TO_W)) u_wdog (
        .i_clk     (SD_CLK),
        .i_rst     (RESET),
        .i_en      (r_state == S_STROBE),
        .i_clr     (r_state != S_STROBE),
        .i_limit   (r_timeout),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge SD_CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_blk_inc   = 1'b0;
        w_err_set   = 1'b0;
        w_err_val   = ERR_NONE;
        case (r_state)
            S_IDLE: begin
                if (bus.start_DMA) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_WAIT_FIFO;
                end
            end
            S_WAIT_FIFO: begin
                if (bus.fifo_ok_FIFO) w_state_nxt = S_STROBE;
            end
            S_STROBE: begin
                // A completion in the expiry cycle wins over the timeout.
                if (bus.complete_Phy) begin
                    w_blk_inc   = 1'b1;
                    w_state_nxt = S_ACK;
                end else if (w_expired) begin
                    w_err_set   = 1'b1;
                    w_err_val   = ERR_TIMEOUT;
                    w_state_nxt = S_ERROR;
                end
            end
            S_ACK: begin
                if (!bus.complete_Phy) begin
                    if (r_pend_err) begin
                        w_err_set   = 1'b1;
                        w_err_val   = ERR_CRC;
                        w_state_nxt = S_ERROR;
                    end else if (r_done_cnt == r_target) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT_FIFO;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge SD_CLK) begin
        if (RESET) begin
            r_wr       <= 1'b0;
            r_mul      <= 1'b0;
            r_blocks   <= '0;
            r_timeout  <= '0;
            r_target   <= '0;
            r_done_cnt <= '0;
            r_err      <= ERR_NONE;
            r_pend_err <= 1'b0;
        end else begin
            if (w_latch) begin
                r_wr       <= bus.writeRead_REG;
                r_mul      <= bus.multiple_REG;
                r_blocks   <= bus.blocks_REG;
                r_timeout  <= bus.timeout_REG;
                r_target   <= w_target;
                r_done_cnt <= '0;
                r_err      <= ERR_NONE;
                r_pend_err <= 1'b0;
            end
            if (w_blk_inc) begin
                r_done_cnt <= r_done_cnt + BLK_W'(1);
                r_pend_err <= bus.crc_err_Phy;
            end
            if (w_err_set) r_err <= w_err_val;
        end
    end

    assign bus.strobe_OUT_DATA_Phy   = (r_state == S_STROBE);
    assign bus.ack_OUT_DATA_Phy      = (r_state == S_ACK);
    assign bus.transfer_complete_IRQ = (r_state == S_DONE);
    assign bus.error_IRQ             = (r_state == S_ERROR);
    assign bus.busy                  = (r_state != S_IDLE);
    assign bus.writeRead_DATA_Phy    = r_wr;
    assign bus.multiple_DATA_Phy     = r_mul;
    assign bus.blocks_DATA_Phy       = r_blocks;
    assign bus.timeout_Reg_DATA_Phy  = r_timeout;
    assign bus.blocks_done           = r_done_cnt;
    assign bus.err_code              = r_err;
endmodule

// File: doc/sd_data_control.md
# sd_data_control

Host-side DATA control unit of the SD host: takes a transfer request from the register/DMA side, latches its configuration and drives the DATA physical layer with a per-block strobe/ack handshake. It counts completed blocks and applies an optional watchdog. It reports completion or error as one-cycle interrupt pulses. It sits between the register file/FIFO and the DATA physical layer, and is the initiator end of the physical layer's strobe/ack interface.

## Interface
- BLK_W, 4: width of block count fields
- TO_W, 16: width of timeout fields
- SD_CLK  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- start_DMA  in  1  one-cycle transfer request; ignored unless busy=0
- writeRead_REG  in  1  1 = write (host→card), 0 = read
- multiple_REG  in  1  1 = multi-block transfer
- blocks_REG  in  BLK_W  block count; 0 treated as 1
- timeout_REG  in  TO_W  watchdog limit in SD_CLK cycles; 0 disables
- fifo_ok_FIFO  in  1  write: FIFO holds one full block; read: FIFO has room for one block
- complete_Phy  in  1  physical layer finished current block
- crc_err_Phy  in  1  CRC/status error, valid while complete_Phy=1
- strobe_OUT_DATA_Phy  out  1  start-block request to physical layer
- ack_OUT_DATA_Phy  out  1  acknowledge of complete_Phy
- writeRead_DATA_Phy, multiple_DATA_Phy  out  1 each  latched configuration
- blocks_DATA_Phy  out  BLK_W  latched block count
- timeout_Reg_DATA_Phy  out  TO_W  latched timeout
- busy  out  1  high in every state except IDLE
- blocks_done  out  BLK_W  blocks acknowledged in current transfer
- err_code  out  2  00 none, 01 CRC, 10 timeout; held until next start
- transfer_complete_IRQ  out  1  one-cycle pulse
- error_IRQ  out  1  one-cycle pulse

## Operation
- States: IDLE, WAIT_FIFO, STROBE, ACK, DONE, ERROR.
- IDLE, start_DMA=1:
  - latch all *_REG inputs
  - target = 1 if multiple_REG=0 or blocks_REG=0, else blocks_REG
  - clear blocks_done and err_code
  - go to WAIT_FIFO
- WAIT_FIFO: fifo_ok_FIFO=1 → STROBE.
- STROBE: strobe_OUT=1. On complete_Phy=1:
  - sample crc_err_Phy into a pending-error flag
  - increment blocks_done
  - go to ACK
- ACK: ack_OUT=1 until complete_Phy=0. Then:
  - pending error → ERROR, err_code=01
  - else blocks_done==target → DONE
  - else → WAIT_FIFO
- DONE: transfer_complete_IRQ=1 for one cycle → IDLE.
- ERROR: error_IRQ=1 for one cycle → IDLE.
- Configuration outputs stay stable from latch until the next accepted start. Mid-transfer changes on *_REG have no effect.
- start_DMA while busy=1 is dropped, not queued.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-transfer: all outputs return to 0 at the next edge. Strobe and ack drop without a handshake.

## Timing
- start_DMA edge to strobe_OUT: 2 cycles when fifo_ok_FIFO is already 1 (IDLE→WAIT_FIFO→STROBE).
- complete_Phy high to ack_OUT high: 1 cycle. strobe_OUT falls on the same edge that ack_OUT rises.
- complete_Phy low to ack_OUT low: 1 cycle. Next strobe follows after ≥1 WAIT_FIFO cycle.
- IRQ pulses occur exactly one cycle after leaving ACK (or after the watchdog trip). busy falls on the following edge.
- blocks_done wraps never: target ≤ 2^BLK_W−1.

## Configuration
- SD_DATA_CTRL_WATCHDOG_EN defined:
  - a TO_W-bit counter clears on entry to STROBE and increments each cycle in STROBE
  - counter reaching timeout_REG (≠0) with complete_Phy=0 → ERROR, err_code=10; strobe_OUT drops next edge
  - complete_Phy=1 in the expiry cycle takes precedence over the timeout
- Not defined: no counter. STROBE waits indefinitely; err_code never reports 10.

## Structure
- Package sd_data_pkg holds:
  - state enum
  - err_code constants (ERR_NONE, ERR_CRC, ERR_TIMEOUT)
  - BLK_W/TO_W defaults
- Sub-module sd_data_watchdog (counter + compare, enable, clear, expired output). Instantiated only under SD_DATA_CTRL_WATCHDOG_EN.

## Test plan
- Single write, blocks_REG=4'hF, multiple_REG=0, fifo_ok_FIFO=1, complete_Phy after 10 cycles → exactly one strobe; transfer_complete_IRQ pulse; blocks_done=1.
- Multi read, blocks_REG=3, three complete/ack handshakes → three strobes; blocks_done=3; one transfer_complete_IRQ; err_code=00.
- Multi write, blocks_REG=2, crc_err_Phy=1 with first complete_Phy → error_IRQ after ack release; err_code=01; no second strobe.
- Watchdog on, timeout_REG=100, complete_Phy never asserted → strobe drops 100 cycles after rising; error_IRQ; err_code=10. Repeat with complete_Phy in the expiry cycle → ACK, no error.
- RESET=1 during ACK of block 2 of 4 → next edge all outputs 0, busy=0. A new start_DMA is accepted normally.
- start_DMA pulsed during STROBE → ignored; latched blocks_DATA_Phy unchanged.
